// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types shared by the host-side blocks.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_arb_tag_fifo.sv
// In-order FIFO of granted host indices; the head names the host owning the next D beat.
module tlul_arb_tag_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CntW-1:0]  count
);

  logic [Depth-1:0][Width-1:0] mem;
  logic [PtrW-1:0]             wptr, rptr;
  logic                        push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CntW'(Depth));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= ptr_inc(wptr);
      if (pop_ok)  rptr <= ptr_inc(rptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tlul_rr_arbiter.sv
// Round-robin share of one TL-UL device port among M hosts; responses are
// steered back through an in-order tag FIFO so a_source is left untouched.
module tlul_rr_arbiter
  import tlul_pkg::*;
#(
  parameter int unsigned M              = 2,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxW = $clog2(M),
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tl_h2d_t           tl_h_i [M],
  output tl_d2h_t           tl_h_o [M],
  output tl_h2d_t           tl_d_o,
  input  tl_d2h_t           tl_d_i,
  output logic [CntW-1:0]   outstanding_o,
  output logic              idle_o,
  output logic              err_o
);

  logic [IdxW-1:0] rr_ptr, lock_idx, grant, head;
  logic            lock, err_q;
  logic            fifo_empty, fifo_full;
  logic [CntW-1:0] count;
  logic            a_hs, d_hs;

  // Rotating priority scan starting at rr_ptr; a pending stalled request pins the grant.
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = rr_ptr;
    for (int k = 0; k < int'(M); k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= int'(M)) idx = idx - int'(M);
      if (!found && tl_h_i[IdxW'(idx)].a_valid) begin
        grant = IdxW'(idx);
        found = 1'b1;
      end
    end
    if (lock) grant = lock_idx;
  end

  always_comb begin
    tl_d_o         = tl_h_i[grant];
    tl_d_o.a_valid = rst_ni & tl_h_i[grant].a_valid & ~fifo_full;
    tl_d_o.d_ready = rst_ni & (fifo_empty | tl_h_i[head].d_ready);
  end

  // Only the FIFO head sees the D beat; only the granted host sees a_ready.
  always_comb begin
    for (int i = 0; i < int'(M); i++) begin
      tl_h_o[i] = '0;
      if (rst_ni && !fifo_empty && head == IdxW'(i)) tl_h_o[i] = tl_d_i;
      tl_h_o[i].a_ready = rst_ni & (grant == IdxW'(i)) & tl_d_i.a_ready & ~fifo_full;
    end
  end

  assign a_hs = tl_d_o.a_valid & tl_d_i.a_ready;
  assign d_hs = tl_d_i.d_valid & tl_d_o.d_ready;

  tlul_arb_tag_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_tag_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (a_hs),
    .pop    (d_hs & ~fifo_empty),
    .wdata  (grant),
    .rdata  (head),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (count)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      err_q    <= 1'b0;
    end else begin
      if (a_hs) begin
        rr_ptr <= (grant == IdxW'(M - 1)) ? '0 : grant + IdxW'(1);
        lock   <= 1'b0;
      end else if (tl_d_o.a_valid) begin
        lock     <= 1'b1;
        lock_idx <= grant;
      end
      if (tl_d_i.d_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign outstanding_o = count;
  assign idle_o        = (count == '0) & ~tl_d_o.a_valid;
  assign err_o         = err_q;

endmodule

// File: tb/tb_tlul_rr_arbiter.sv
// Directed checks of tlul_rr_arbiter with M=2, MaxOutstanding=4.
module tb_tlul_rr_arbiter;
  import tlul_pkg::*;

  logic    clk;
  logic    rst_n;
  tl_h2d_t tl_h  [2];
  tl_d2h_t tl_ho [2];
  tl_h2d_t tl_do;
  tl_d2h_t tl_di;
  logic [2:0] outstanding;
  logic    idle, err;

  int checks = 0;
  int errors = 0;

  tlul_rr_arbiter #(.M(2), .MaxOutstanding(4)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .tl_h_i        (tl_h),
    .tl_h_o        (tl_ho),
    .tl_d_o        (tl_do),
    .tl_d_i        (tl_di),
    .outstanding_o (outstanding),
    .idle_o        (idle),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic host(input int h, input logic v, input logic [31:0] addr);
    tl_h[h].a_valid   = v;
    tl_h[h].a_opcode  = Get;
    tl_h[h].a_param   = '0;
    tl_h[h].a_size    = 2'd2;
    tl_h[h].a_source  = 8'(h);
    tl_h[h].a_address = addr;
    tl_h[h].a_mask    = 4'hF;
    tl_h[h].a_data    = '0;
    tl_h[h].d_ready   = 1'b1;
  endtask

  task automatic dev_rsp(input logic v, input logic [31:0] data);
    tl_di.d_valid  = v;
    tl_di.d_opcode = AccessAckData;
    tl_di.d_data   = data;
  endtask

  initial begin
    rst_n = 1'b0;
    tl_di = '0;
    host(0, 1'b1, 32'h10);
    host(1, 1'b0, 32'h0);
    tl_di.a_ready = 1'b1;
    tick(); tick();
    #1;
    chk("rst_a_valid", tl_do.a_valid, 0);
    chk("rst_d_ready", tl_do.d_ready, 0);
    chk("rst_a_ready0", tl_ho[0].a_ready, 0);
    chk("rst_a_ready1", tl_ho[1].a_ready, 0);
    chk("rst_d_valid0", tl_ho[0].d_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", err, 0);
    tick();
    rst_n = 1'b1;
    host(0, 1'b0, 32'h0);

    // basic routing: host1 Get 0x100
    host(1, 1'b1, 32'h100);
    #1;
    chk("basic_a_valid", tl_do.a_valid, 1);
    chk("basic_addr", tl_do.a_address, 32'h100);
    chk("basic_a_ready1", tl_ho[1].a_ready, 1);
    chk("basic_a_ready0", tl_ho[0].a_ready, 0);
    tick();
    chk("basic_out1", outstanding, 1);
    host(1, 1'b0, 32'h0);
    dev_rsp(1'b1, 32'hDEADBEEF);
    #1;
    chk("basic_d_valid1", tl_ho[1].d_valid, 1);
    chk("basic_d_data1", tl_ho[1].d_data, 32'hDEADBEEF);
    chk("basic_d_valid0", tl_ho[0].d_valid, 0);
    chk("basic_d_ready", tl_do.d_ready, 1);
    tick();
    dev_rsp(1'b0, 32'h0);
    #1;
    chk("basic_out0", outstanding, 0);
    chk("basic_err", err, 0);

    // round-robin: both hosts request, device answers one cycle after each accept
    for (int k = 0; k <= 8; k++) begin
      tick();
      host(0, k < 8, 32'h200);
      host(1, k < 8, 32'h300);
      dev_rsp(k >= 1, 32'(k - 1));
      #1;
      if (k < 8) chk($sformatf("rr_addr%0d", k), tl_do.a_address, (k % 2) ? 32'h300 : 32'h200);
      chk($sformatf("rr_out%0d", k), outstanding, (k == 0) ? 0 : 1);
      if (k >= 1) begin
        chk($sformatf("rr_dv%0d", k), tl_ho[(k - 1) % 2].d_valid, 1);
        chk($sformatf("rr_dd%0d", k), tl_ho[(k - 1) % 2].d_data, 32'(k - 1));
        chk($sformatf("rr_dvx%0d", k), tl_ho[k % 2].d_valid, 0);
      end
    end
    tick();
    dev_rsp(1'b0, 32'h0);
    #1;
    chk("rr_out_end", outstanding, 0);

    // backpressure lock: move rr_ptr to host1 first
    host(0, 1'b1, 32'h3F0);
    tick();
    host(0, 1'b0, 32'h0);
    dev_rsp(1'b1, 32'h1);
    tick();
    dev_rsp(1'b0, 32'h0);
    tl_di.a_ready = 1'b0;
    host(0, 1'b1, 32'h400);
    #1;
    chk("lock_addr0", tl_do.a_address, 32'h400);
    chk("lock_a_ready0", tl_ho[0].a_ready, 0);
    tick();
    host(1, 1'b1, 32'h500);
    for (int c = 1; c <= 2; c++) begin
      #1;
      chk($sformatf("lock_addr%0d", c), tl_do.a_address, 32'h400);
      chk($sformatf("lock_valid%0d", c), tl_do.a_valid, 1);
      chk($sformatf("lock_a_ready1_%0d", c), tl_ho[1].a_ready, 0);
      tick();
    end
    tl_di.a_ready = 1'b1;
    #1;
    chk("lock_hs_addr", tl_do.a_address, 32'h400);
    chk("lock_hs_ready0", tl_ho[0].a_ready, 1);
    tick();
    host(0, 1'b0, 32'h0);
    #1;
    chk("lock_next_addr", tl_do.a_address, 32'h500);
    chk("lock_next_ready1", tl_ho[1].a_ready, 1);
    tick();
    host(1, 1'b0, 32'h0);
    chk("lock_out2", outstanding, 2);
    dev_rsp(1'b1, 32'hA0);
    #1;
    chk("lock_rsp0", tl_ho[0].d_valid, 1);
    tick();
    #1;
    chk("lock_rsp1", tl_ho[1].d_valid, 1);
    tick();
    dev_rsp(1'b0, 32'h0);
    #1;
    chk("lock_out0", outstanding, 0);

    // full stall
    host(0, 1'b1, 32'h600);
    repeat (4) tick();
    #1;
    chk("full_out4", outstanding, 4);
    chk("full_a_ready", tl_ho[0].a_ready, 0);
    chk("full_a_valid", tl_do.a_valid, 0);
    chk("full_idle", idle, 0);
    dev_rsp(1'b1, 32'hB0);
    #1;
    chk("full_pop_dv", tl_ho[0].d_valid, 1);
    chk("full_pop_a_valid", tl_do.a_valid, 0);
    tick();
    dev_rsp(1'b0, 32'h0);
    #1;
    chk("full_out3", outstanding, 3);
    chk("full_5th_ready", tl_ho[0].a_ready, 1);
    chk("full_5th_valid", tl_do.a_valid, 1);
    tick();
    host(0, 1'b0, 32'h0);
    chk("full_out4b", outstanding, 4);
    dev_rsp(1'b1, 32'hC0);
    repeat (4) tick();
    dev_rsp(1'b0, 32'h0);
    #1;
    chk("full_drain", outstanding, 0);
    chk("full_idle_end", idle, 1);

    // stray response
    dev_rsp(1'b1, 32'hBAD);
    #1;
    chk("stray_d_ready", tl_do.d_ready, 1);
    chk("stray_dv0", tl_ho[0].d_valid, 0);
    chk("stray_dv1", tl_ho[1].d_valid, 0);
    chk("stray_err_pre", err, 0);
    tick();
    dev_rsp(1'b0, 32'h0);
    chk("stray_err", err, 1);
    tick();
    chk("stray_err_sticky", err, 1);

    // reset mid-flight: two host0 accepts leave rr_ptr at host1
    host(0, 1'b1, 32'h700);
    tick(); tick();
    host(0, 1'b0, 32'h0);
    chk("mid_out2", outstanding, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_out0", outstanding, 0);
    chk("mid_idle", idle, 1);
    chk("mid_err", err, 0);
    dev_rsp(1'b1, 32'hD0);
    tick();
    dev_rsp(1'b0, 32'h0);
    chk("mid_late_err", err, 1);
    host(0, 1'b1, 32'h700);
    host(1, 1'b1, 32'h710);
    #1;
    chk("mid_grant_addr", tl_do.a_address, 32'h700);
    chk("mid_grant_ready0", tl_ho[0].a_ready, 1);
    chk("mid_grant_ready1", tl_ho[1].a_ready, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlul_rr_arbiter.md
Name: tlul_rr_arbiter

Overview:
- Round-robin arbiter that shares one TL-UL device port between M TL-UL hosts, such as the Ibex data and instruction ports.
- Response routing uses an in-order tag FIFO of granted host indices. Source fields are not rewritten, so hosts keep their full a_source space.
- Sits between the core's host ports and the system crossbar.
- Adds bounded outstanding tracking, an error flag and idle status.

Parameters:
- M, 2: number of hosts; must be ≥2.
- MaxOutstanding, 4: tag FIFO depth, i.e. maximum accepted but unanswered A transactions; must be ≥1.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, synchronous, active-low
- tl_h_i  input  tlul_pkg::tl_h2d_t [M]  host requests
- tl_h_o  output  tlul_pkg::tl_d2h_t [M]  host responses
- tl_d_o  output  tlul_pkg::tl_h2d_t  device request
- tl_d_i  input  tlul_pkg::tl_d2h_t  device response
- outstanding_o  output  $clog2(MaxOutstanding+1)  current FIFO occupancy
- idle_o  output  1  occupancy 0 and no a_valid on tl_d_o
- err_o  output  1  sticky: device d_valid arrived with FIFO empty

Behaviour:
- Reset: one clock, one reset (rst_ni synchronous active-low). While rst_ni=0 at a clk_i edge:
  - FIFO emptied, rr_ptr=0, lock cleared, err_o=0.
  - Combinational outputs then settle to: tl_d_o.a_valid=0, tl_d_o.d_ready=0, all tl_h_o[i].a_ready=0, all tl_h_o[i].d_valid=0, outstanding_o=0, idle_o=1.
- Reset mid-transaction: in-flight tags are discarded. Late device responses after reset set err_o.
- Full flag: full = (occupancy == MaxOutstanding).
- Grant selection:
  - If the lock is set, grant = locked host.
  - Otherwise grant = the first host i with tl_h_i[i].a_valid, scanning rr_ptr, rr_ptr+1, … mod M.
  - Selection is combinational, so there is zero latency from host to device.
- A channel:
  - tl_d_o = tl_h_i[grant] with a_valid gated by !full and d_ready replaced per the D-channel rule.
  - tl_h_o[grant].a_ready = tl_d_i.a_ready & !full. Other hosts see a_ready=0.
- Lock (TL-UL stability):
  - Set when tl_d_o.a_valid=1 and tl_d_i.a_ready=0.
  - Cleared on the A handshake.
  - While set, the grant cannot move.
- A handshake (tl_d_o.a_valid & tl_d_i.a_ready):
  - Push grant index into the FIFO.
  - rr_ptr <= (grant+1) mod M.
- Full:
  - No A request is forwarded, even if a pop occurs in the same cycle. The pop frees space for the next cycle.
  - The lock is not set while full, because a_valid is gated.
- D channel, FIFO non-empty (head index h):
  - tl_h_o[h] = tl_d_i, except a_ready per the A rule.
  - tl_d_o.d_ready = tl_h_i[h].d_ready.
  - Other hosts see d_valid=0.
- D handshake (tl_d_i.d_valid & tl_d_o.d_ready): pop the FIFO.
- Simultaneous push and pop: occupancy unchanged; pointers both advance.
- D channel, FIFO empty:
  - tl_d_o.d_ready=1, so the stray response is drained.
  - No host sees d_valid.
  - err_o sets on d_valid and stays set until reset.
- Combinational paths: D-side outputs depend only on registered FIFO state and tl_d_i/tl_h_i. There is no path from tl_d_i.a_ready into the grant selection.
- Ordering: the device side is required to respond in order. The team's single-target devices do.

Decomposition:
- No new package. Use tlul_pkg types. IdxW = $clog2(M) and CntW are local parameters.
- One sub-module: tlul_arb_tag_fifo, a synchronous FIFO of IdxW-bit tags with depth MaxOutstanding.
  - Ports: push, pop, wdata, rdata, empty, full, count.
  - Same clk_i/rst_ni scheme.
- Top level holds rr_ptr, lock and err, plus combinational muxing.

Test Plan:
- Basic routing: M=2; host1 issues a Get at 0x100; device returns data 0xDEADBEEF one cycle later.
  - Required: host1 receives d_valid with 0xDEADBEEF; host0 sees d_valid=0.
  - outstanding_o goes 0→1→0.
- Round-robin fairness: both hosts hold a_valid continuously; device a_ready=1, d_ready path always ready.
  - Required: grants alternate 0,1,0,1 for 8 requests.
  - Responses are delivered to hosts in the same order.
- Backpressure lock: host0 a_valid with device a_ready=0 for 3 cycles while host1 also requests.
  - Required: tl_d_o stays host0's request, stable for all 3 cycles.
  - Host1 is granted only after host0's handshake.
- Full stall: MaxOutstanding=4; issue 4 accepted Gets with no responses.
  - Required: outstanding_o=4; a 5th request sees a_ready=0.
  - After one D handshake, the 5th is accepted on the following cycle.
- Stray response: device drives d_valid with the FIFO empty.
  - Required: tl_d_o.d_ready=1, no host d_valid, err_o=1 from the next cycle until reset.
- Synchronous reset mid-flight: 2 outstanding requests, then rst_ni=0 for one cycle.
  - Required: outstanding_o=0, idle_o=1, err_o=0.
  - A later device response sets err_o.
  - The next host request is granted starting from host0.
